// File: rtl/hilo_mul_ctrl.sv
// HI/LO register owner and sequencer for an external iterative 32x32 unsigned shift-add multiplier.
// Handles MULTU, MFHI/MFLO and MTHI/MTLO, and stalls the pipeline while a multiply is in flight.
module hilo_mul_ctrl #(
    parameter int ITER = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        flush,
    input  logic        mf_req,
    input  logic        mf_sel,
    output logic [31:0] mf_data,
    input  logic        mt_we,
    input  logic        mt_sel,
    input  logic [31:0] mt_data,
    output logic        stall,
    output logic        done,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    output logic        mul_clear,
    output logic        mul_run,
    input  logic [63:0] mul_product,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, CAPT} state_t;

    localparam logic [4:0] CNT_LAST = 5'(ITER - 1);

    state_t     state_reg, state_next;
    logic [4:0] cnt_reg, cnt_next;
    logic       accept;
    logic       capture;
    logic       mt_write;
    logic       is_idle;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Strobes come straight from the state register; done additionally
    // drops when a flush lands in CAPT so no stale completion is reported.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        start_ready = 1'b0;
        mul_clear   = 1'b0;
        mul_run     = 1'b0;
        done        = 1'b0;
        accept      = 1'b0;
        capture     = 1'b0;
        case (state_reg)
            IDLE: begin
                start_ready = 1'b1;
                if (start_valid && !flush) begin
                    accept     = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                mul_clear  = 1'b1;
                cnt_next   = '0;
                state_next = RUN;
            end
            RUN: begin
                mul_run = 1'b1;
                if (cnt_reg == CNT_LAST) begin
                    state_next = CAPT;
                end else begin
                    cnt_next = cnt_reg + 5'd1;
                end
            end
            CAPT: begin
                done       = !flush;
                capture    = !flush;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (flush && state_reg != IDLE) begin
            state_next = IDLE;
        end
    end

    assign is_idle  = (state_reg == IDLE);
    // An MT racing a MULTU loses: it is stalled and replayed after the multiply.
    assign mt_write = is_idle && mt_we && !start_valid;
    assign stall    = ((mf_req || mt_we) && !is_idle) || (is_idle && mt_we && start_valid);
    assign mf_data  = mf_sel ? hi : lo;

    always_ff @(posedge clk) begin
        if (reset) begin
            mul_a <= '0;
            mul_b <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            if (accept) begin
                mul_a <= op_a;
                mul_b <= op_b;
            end
            if (capture) begin
                hi <= mul_product[63:32];
                lo <= mul_product[31:0];
            end else if (mt_write) begin
                if (mt_sel) begin
                    hi <= mt_data;
                end else begin
                    lo <= mt_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_hilo_mul_ctrl.sv
// Bench for hilo_mul_ctrl: a behavioural shift-add multiplier feeds mul_product,
// and HI/LO expectations come from plain 64-bit multiplication and MT writes.
module tb_hilo_mul_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        flush = 1'b0;
    logic        mf_req = 1'b0;
    logic        mf_sel = 1'b0;
    logic [31:0] mf_data;
    logic        mt_we = 1'b0;
    logic        mt_sel = 1'b0;
    logic [31:0] mt_data = '0;
    logic        stall;
    logic        done;
    logic [31:0] mul_a;
    logic [31:0] mul_b;
    logic        mul_clear;
    logic        mul_run;
    logic [63:0] mul_product;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int passed = 0;
    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;

    hilo_mul_ctrl #(.ITER(32)) dut (
        .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
        .op_a(op_a), .op_b(op_b), .flush(flush), .mf_req(mf_req), .mf_sel(mf_sel),
        .mf_data(mf_data), .mt_we(mt_we), .mt_sel(mt_sel), .mt_data(mt_data),
        .stall(stall), .done(done), .mul_a(mul_a), .mul_b(mul_b), .mul_clear(mul_clear),
        .mul_run(mul_run), .mul_product(mul_product), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Behavioural shift-add multiplier: one partial product per run cycle.
    int bit_idx = 0;
    always @(posedge clk) begin
        if (reset || mul_clear) begin
            mul_product <= '0;
            bit_idx     <= 0;
        end else if (mul_run && bit_idx < 32) begin
            if (mul_b[bit_idx]) mul_product <= mul_product + ({32'd0, mul_a} << bit_idx);
            bit_idx <= bit_idx + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mt_write(input logic sel, input logic [31:0] data);
        mt_we = 1'b1; mt_sel = sel; mt_data = data; start_valid = 1'b0;
        #1;
        check("mt_no_stall", {63'd0, stall}, 64'd0);
        tick();
        mt_we = 1'b0;
        if (sel) hi_m = data; else lo_m = data;
        check("mt_hi", {32'd0, hi}, {32'd0, hi_m});
        check("mt_lo", {32'd0, lo}, {32'd0, lo_m});
        $display("MT%s 0x%08h -> hi=0x%08h lo=0x%08h", sel ? "HI" : "LO", data, hi, lo);
    endtask

    // abort_at: busy cycle (1 = LOAD) at which flush/reset is raised; 0 = none.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input int abort_at,
                           input bit use_reset, input bit mf_hold);
        int n_clear = 0, n_run = 0, done_at = 0, stall_bad = 0, opnd_bad = 0, last_k = 34;
        logic [31:0] hi0 = hi_m, lo0 = lo_m;
        start_valid = 1'b1; op_a = a; op_b = b;
        #1;
        check("accept_ready", {63'd0, start_ready}, 64'd1);
        check("accept_stall", {63'd0, stall}, {63'd0, mt_we});
        tick();
        start_valid = 1'b0; op_a = $urandom; op_b = $urandom;
        for (int k = 1; k <= 34; k++) begin
            if (mf_hold && k == 1) mf_req = 1'b1;
            if (k == abort_at) begin
                if (use_reset) reset = 1'b1; else flush = 1'b1;
            end
            #1;
            n_clear += int'(mul_clear);
            n_run   += int'(mul_run);
            if (done) done_at = k;
            if (stall !== (mf_req | mt_we)) stall_bad++;
            if (mul_a !== a || mul_b !== b) opnd_bad++;
            tick();
            if (k == abort_at) begin
                last_k = k;
                break;
            end
        end
        check("busy_stall", stall_bad, 0);
        check("operands_stable", opnd_bad, 0);
        check("clear_count", n_clear, 1);
        check("run_count", n_run, (last_k >= 33) ? 32 : last_k - 1);
        if (abort_at == 0) begin
            {hi_m, lo_m} = 64'(a) * 64'(b);
            check("done_cycle", done_at, 34);
        end else if (use_reset) begin
            hi_m = '0; lo_m = '0;
            check("done_cycle", done_at, 0);
            #1;
            check("rst_mul_a", {32'd0, mul_a}, 64'd0);
            check("rst_mul_b", {32'd0, mul_b}, 64'd0);
            check("rst_strobes", {61'd0, mul_clear, mul_run, done}, 64'd0);
            check("rst_stall", {63'd0, stall}, 64'd0);
            reset = 1'b0;
        end else begin
            check("done_cycle", done_at, 0);
            flush = 1'b0;
            hi_m = hi0; lo_m = lo0;
        end
        #1;
        check("idle_ready", {63'd0, start_ready}, 64'd1);
        check("idle_run", {63'd0, mul_run}, 64'd0);
        check("hi", {32'd0, hi}, {32'd0, hi_m});
        check("lo", {32'd0, lo}, {32'd0, lo_m});
        if (mf_hold) begin
            mf_sel = 1'b0;
            #1;
            check("mf_stall_end", {63'd0, stall}, 64'd0);
            check("mf_data", {32'd0, mf_data}, {32'd0, lo_m});
            mf_req = 1'b0;
        end
        $display("MULTU 0x%08h x 0x%08h abort=%0d -> hi=0x%08h lo=0x%08h", a, b, abort_at, hi, lo);
    endtask

    initial begin
        tick(); tick();
        check("rst_ready", {63'd0, start_ready}, 64'd1);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_ops", {mul_a, mul_b}, 64'd0);
        check("rst_outs", {60'd0, mul_clear, mul_run, done, stall}, 64'd0);
        reset = 1'b0;
        #1;

        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, 1'b0);
        check("max_hi", {32'd0, hi}, 64'hFFFF_FFFE);
        check("max_lo", {32'd0, lo}, 64'h1);

        run_mul(32'd7, 32'd6, 0, 1'b0, 1'b1);
        check("seven_six_hi", {32'd0, hi}, 64'd0);

        mt_write(1'b1, 32'h1234_5678);
        run_mul(32'd0, 32'd5, 0, 1'b0, 1'b0);

        mt_write(1'b1, 32'hA);
        mt_write(1'b0, 32'hB);
        run_mul(32'd3, 32'd3, 11, 1'b0, 1'b0);   // flush in RUN cycle 10
        run_mul(32'd3, 32'd3, 34, 1'b0, 1'b0);   // flush in CAPT

        // Flush in IDLE blocks a simultaneous start.
        start_valid = 1'b1; flush = 1'b1; op_a = 32'd9; op_b = 32'd9;
        tick();
        start_valid = 1'b0; flush = 1'b0;
        #1;
        check("idle_flush_no_accept", {62'd0, start_ready, mul_clear}, 64'b10);

        // MTLO racing a MULTU: stalled, retried after completion.
        mt_we = 1'b1; mt_sel = 1'b0; mt_data = 32'h55;
        run_mul(32'd2, 32'd4, 0, 1'b0, 1'b0);
        mt_write(1'b0, 32'h55);
        check("retry_hi", {32'd0, hi}, 64'd0);

        run_mul($urandom, $urandom, 21, 1'b1, 1'b0);  // reset in RUN cycle 20
        run_mul(32'h1_0000, 32'h1_0000, 0, 1'b0, 1'b0);
        check("pow_hi", {32'd0, hi}, 64'd1);
        check("pow_lo", {32'd0, lo}, 64'd0);

        for (int i = 0; i < 6; i++) begin
            run_mul($urandom, $urandom, 0, 1'b0, i[0]);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
